add_arbiter: RTL and testbench
==============================

# add_arbiter

Round-robin arbiter and sequencer that shares one 4-bit ripple-carry adder (`addition`, A/B 4-bit in, Y 5-bit out) between two requesters. It accepts one operand pair at a time over a valid/ready handshake and latches the operands into the adder's inputs. It registers the 5-bit sum and returns it on a shared response channel tagged with the requester ID. It sits between the two operand-producing clients and the single adder instance, and it owns the adder exclusively.

## Interface
- CNT_W, 8, width of the completed-operation counter

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- r0_valid  in  1  requester 0 has an operand pair
- r0_a, r0_b  in  4 each  requester 0 operands
- r0_ready  out  1  requester 0 handshake accept
- r1_valid  in  1  requester 1 has an operand pair
- r1_a, r1_b  in  4 each  requester 1 operands
- r1_ready  out  1  requester 1 handshake accept
- resp_valid  out  1  response holds a valid sum
- resp_id  out  1  requester that owns the response
- resp_sum  out  5  registered sum, bit 4 = carry-out
- resp_ready  in  1  consumer accepts the response
- busy  out  1  high in any state other than IDLE
- op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W

## Operation
- One clock; reset is synchronous and active-high (ports `clk`, `rst`).
- FSM states: IDLE, CALC, RESP.
- Round-robin pointer `prio`, 1 bit, names the favoured requester.
- **IDLE**
  - Winner logic:
    - If both valids are high, the winner is `prio`.
    - If one valid is high, that requester wins.
    - If neither is high, there is no winner.
  - `rX_ready` is combinational: asserted only for the winner while in IDLE. Both are 0 in every other state.
  - A handshake is valid && ready. On a handshake the block latches op_a/op_b from the winner, latches owner = winner ID, and moves to CALC.
- **CALC**
  - The adder is driven from op_a/op_b only, never from the raw request ports.
  - Adder Y is captured into resp_sum and owner into resp_id. resp_valid is set to 1. Next state is RESP.
- **RESP**
  - resp_valid stays high. resp_sum and resp_id stay stable until resp_valid && resp_ready.
  - On that handshake:
    - resp_valid goes to 0.
    - op_count increments.
    - prio becomes ~owner.
    - Next state is IDLE.
- Arithmetic: resp_sum = {carry, sum} of the 4-bit unsigned operands, range 0..30. There is no overflow or truncation.
- Requester rule: valid may drop before ready without effect. Once raised, operands must stay stable until the handshake. The block does not check this.
- Only one operation is in flight. A requester whose request arrives during CALC or RESP waits.
- Reset values:
  - State IDLE, prio = 0.
  - op_a = op_b = 0, owner = 0.
  - resp_valid = 0, resp_id = 0, resp_sum = 0.
  - op_count = 0, busy = 0.
  - r0_ready and r1_ready follow IDLE rules, so they are 0 unless the matching valid is high.
- Reset in CALC or RESP discards the in-flight operation: no response is produced and op_count is unchanged. Reset overrides any handshake in the same cycle.

## Timing
- Request accepted at edge N (IDLE→CALC).
- Sum registered at edge N+1, so resp_valid is high from cycle N+1 through N+2.
- If resp_ready is already high, the response completes at edge N+2 and the FSM is back in IDLE for cycle N+2..N+3.
- Minimum initiation interval is 3 cycles per operation. Back-to-back requests are served at most once per 3 cycles.
- Fairness: with both valids held high continuously, grants strictly alternate. The first grant after reset goes to r0.
- Backpressure: while resp_ready is low, the FSM holds RESP indefinitely and both readies stay 0.
- busy is registered from state and is high in CALC and RESP.

## Test plan
- **Single operation.** After reset, r0 sends 9+8 with resp_ready=1. Required response:
  - r0_ready is high in the request cycle.
  - resp_valid rises 1 cycle after the handshake, with resp_sum=5'd17 and resp_id=0.
  - op_count=1 after the response.
- **Extremes.**
  - r1 sends 15+15: required resp_sum=5'd30, resp_id=1.
  - r0 sends 0+0: required resp_sum=0.
  - r1 sends 15+1: required resp_sum=5'd16.
- **Contention.** r0 (3+4) and r1 (5+6) are held valid from reset. Required response:
  - Responses arrive in the order id0/7, id1/11, then id0 again if r0 re-requests.
  - Handshakes are 3 cycles apart.
- **Backpressure.** r1 sends 2+2 and resp_ready is held low for 4 cycles. Required response:
  - resp_valid stays high with resp_sum=4 and resp_id=1 stable for the whole period.
  - r0_valid=1 sees r0_ready=0 throughout.
  - r0 is granted in the cycle after resp_ready rises.
- **Reset mid-op.** Assert rst during CALC after r0 sends 7+7. Required response:
  - resp_valid never asserts.
  - op_count=0.
  - busy=0 and prio=0 the cycle after reset.
- **Counter wrap.** With CNT_W=2, complete 5 operations. Required response: op_count reads 1,2,3,0,1.

Source files
------------

// File: rtl/add_arbiter.sv
// Round-robin arbiter that time-shares one 4-bit ripple-carry adder between two
// requesters, returning the registered 5-bit sum tagged with the owner's ID.

module addition (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [4:0] y
);

  logic carry;

  always_comb begin
    carry = 1'b0;
    y     = '0;
    for (int i = 0; i < 4; i++) begin
      y[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    y[4] = carry;
  end

endmodule

module add_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  input  logic [3:0]       r0_a,
  input  logic [3:0]       r0_b,
  output logic             r0_ready,
  input  logic             r1_valid,
  input  logic [3:0]       r1_a,
  input  logic [3:0]       r1_b,
  output logic             r1_ready,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [4:0]       resp_sum,
  input  logic             resp_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t     state;
  state_t     next_state;
  logic       prio;
  logic       owner;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [4:0] adder_y;
  logic       have_winner;
  logic       winner;
  logic       grant;
  logic       resp_done;

  // The adder only ever sees the latched operands, never the live request ports.
  addition u_addition (
    .a(op_a),
    .b(op_b),
    .y(adder_y)
  );

  assign have_winner = r0_valid | r1_valid;
  assign winner      = (r0_valid && r1_valid) ? prio : r1_valid;
  assign resp_done   = (state == RESP) && resp_ready;

  always_comb begin
    next_state = state;
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        if (have_winner) begin
          r0_ready   = ~winner;
          r1_ready   = winner;
          grant      = 1'b1;
          next_state = CALC;
        end
      end
      CALC: next_state = RESP;
      RESP: if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      prio       <= 1'b0;
      owner      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_sum   <= '0;
      op_count   <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      if (grant) begin
        op_a  <= winner ? r1_a : r0_a;
        op_b  <= winner ? r1_b : r0_b;
        owner <= winner;
      end
      if (state == CALC) begin
        resp_sum   <= adder_y;
        resp_id    <= owner;
        resp_valid <= 1'b1;
      end
      // Handing the favour to the other side guarantees alternation under contention.
      if (resp_done) begin
        resp_valid <= 1'b0;
        op_count   <= op_count + 1'b1;
        prio       <= ~owner;
      end
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a transaction model.

module tb_add_arbiter;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             r0_valid = 1'b0;
  logic [3:0]       r0_a = '0;
  logic [3:0]       r0_b = '0;
  logic             r0_ready;
  logic             r1_valid = 1'b0;
  logic [3:0]       r1_a = '0;
  logic [3:0]       r1_b = '0;
  logic             r1_ready;
  logic             resp_valid;
  logic             resp_id;
  logic [4:0]       resp_sum;
  logic             resp_ready = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  add_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_ready(r1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum),
    .resp_ready(resp_ready), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: one op in flight, result visible one edge after acceptance.
  bit m_busy = 1'b0;
  int m_age = 0;
  bit m_owner = 1'b0;
  int m_pend = 0;
  bit m_prio = 1'b0;
  int m_count = 0;
  int m_sum = 0;
  bit m_id = 1'b0;
  bit m_rv = 1'b0;
  bit m_w;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_prio = 1'b0; m_count = 0;
      m_sum = 0; m_id = 1'b0; m_rv = 1'b0;
    end else if (!m_busy) begin
      if (r0_valid || r1_valid) begin
        m_w     = (r0_valid && r1_valid) ? m_prio : r1_valid;
        m_owner = m_w;
        m_pend  = m_w ? int'(r1_a) + int'(r1_b) : int'(r0_a) + int'(r0_b);
        m_busy  = 1'b1;
        m_age   = 0;
      end
    end else if (m_age == 0) begin
      m_age = 1; m_sum = m_pend; m_id = m_owner; m_rv = 1'b1;
    end else if (resp_ready) begin
      m_rv    = 1'b0;
      m_count = (m_count + 1) % (1 << CNT_W);
      m_prio  = !m_owner;
      m_busy  = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cyc_r0_ready", 16'(r0_ready), 16'(!m_busy && r0_valid && (!r1_valid || !m_prio)));
      checkOutput("cyc_r1_ready", 16'(r1_ready), 16'(!m_busy && r1_valid && (!r0_valid || m_prio)));
      checkOutput("cyc_resp_valid", 16'(resp_valid), 16'(m_rv));
      checkOutput("cyc_resp_sum", 16'(resp_sum), 16'(m_sum));
      checkOutput("cyc_resp_id", 16'(resp_id), 16'(m_id));
      checkOutput("cyc_busy", 16'(busy), 16'(m_busy));
      checkOutput("cyc_op_count", 16'(op_count), 16'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    tick(); rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic waitResp(output logic [4:0] sum, output bit rid, output int lat);
    bit seen = 1'b0;
    lat = 0; sum = '0; rid = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) begin seen = 1'b1; sum = resp_sum; rid = resp_id; end
      else lat++;
    end
    if (!seen) checkOutput("resp_timeout", 16'(0), 16'(1));
  endtask

  task automatic finishOp();
    bit done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick(); @(negedge clk);
      if (!resp_valid) done = 1'b1;
    end
    if (!done) checkOutput("finish_timeout", 16'(0), 16'(1));
  endtask

  // Drive one request, wait for its handshake, then for its response; ends on the negedge of the first response cycle.
  task automatic applyStimulus(input bit id, input logic [3:0] a, input logic [3:0] b, input bit want_ready_now,
                               output logic [4:0] sum, output bit rid, output int lat);
    bit got = 1'b0;
    tick();
    if (id) begin r1_valid = 1'b1; r1_a = a; r1_b = b; end
    else    begin r0_valid = 1'b1; r0_a = a; r0_b = b; end
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (i == 0 && want_ready_now) checkOutput("ready_in_request_cycle", 16'(id ? r1_ready : r0_ready), 16'(1));
      if (id ? r1_ready : r0_ready) got = 1'b1;
      tick();
    end
    if (!got) checkOutput("handshake_timeout", 16'(0), 16'(1));
    if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
    waitResp(sum, rid, lat);
  endtask

  logic [4:0] s;
  bit         id;
  int         lat;
  int         wrap_exp [5] = '{1, 2, 3, 0, 1};
  int         hs_cyc [$];
  int         rsp_id [$];
  int         rsp_sum [$];
  bit         hs0, hs1;

  initial begin
    doReset();
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_resp_valid", 16'(resp_valid), 16'(0));
    checkOutput("reset_busy", 16'(busy), 16'(0));
    checkOutput("reset_op_count", 16'(op_count), 16'(0));
    checkOutput("reset_resp_sum", 16'(resp_sum), 16'(0));
    checkOutput("reset_r0_ready", 16'(r0_ready), 16'(0));

    // Single operation
    resp_ready = 1'b1;
    applyStimulus(1'b0, 4'd9, 4'd8, 1'b1, s, id, lat);
    checkOutput("single_sum", 16'(s), 16'(17));
    checkOutput("single_id", 16'(id), 16'(0));
    checkOutput("single_latency", 16'(lat), 16'(1));
    finishOp();
    checkOutput("single_op_count", 16'(op_count), 16'(1));

    // Extremes
    applyStimulus(1'b1, 4'd15, 4'd15, 1'b1, s, id, lat);
    checkOutput("ext_15p15_sum", 16'(s), 16'(30));
    checkOutput("ext_15p15_id", 16'(id), 16'(1));
    finishOp();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, s, id, lat);
    checkOutput("ext_0p0_sum", 16'(s), 16'(0));
    finishOp();
    applyStimulus(1'b1, 4'd15, 4'd1, 1'b1, s, id, lat);
    checkOutput("ext_15p1_sum", 16'(s), 16'(16));
    finishOp();

    // Backpressure
    tick(); resp_ready = 1'b0;
    applyStimulus(1'b1, 4'd2, 4'd2, 1'b1, s, id, lat);
    checkOutput("bp_sum", 16'(s), 16'(4));
    tick(); r0_valid = 1'b1; r0_a = 4'd5; r0_b = 4'd5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", 16'(resp_valid), 16'(1));
      checkOutput("bp_hold_sum", 16'(resp_sum), 16'(4));
      checkOutput("bp_hold_id", 16'(resp_id), 16'(1));
      checkOutput("bp_r0_blocked", 16'(r0_ready), 16'(0));
      tick();
    end
    resp_ready = 1'b1;
    tick(); @(negedge clk);
    checkOutput("bp_r0_granted_after", 16'(r0_ready), 16'(1));
    tick(); r0_valid = 1'b0;
    waitResp(s, id, lat);
    checkOutput("bp_next_sum", 16'(s), 16'(10));
    checkOutput("bp_next_id", 16'(id), 16'(0));
    finishOp();

    // Contention from reset
    tick(); rst = 1'b1;
    r0_valid = 1'b1; r0_a = 4'd3; r0_b = 4'd4;
    r1_valid = 1'b1; r1_a = 4'd5; r1_b = 4'd6;
    tick(); tick(); rst = 1'b0;
    for (int c = 0; c < 40 && rsp_id.size() < 3; c++) begin
      @(negedge clk);
      if ((r0_ready && r0_valid) || (r1_ready && r1_valid)) hs_cyc.push_back(c);
      if (resp_valid && resp_ready) begin rsp_id.push_back(int'(resp_id)); rsp_sum.push_back(int'(resp_sum)); end
      tick();
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    if (rsp_id.size() < 3 || hs_cyc.size() < 3) checkOutput("contention_count", 16'(rsp_id.size()), 16'(3));
    else begin
      checkOutput("cont_id0", 16'(rsp_id[0]), 16'(0));
      checkOutput("cont_sum0", 16'(rsp_sum[0]), 16'(7));
      checkOutput("cont_id1", 16'(rsp_id[1]), 16'(1));
      checkOutput("cont_sum1", 16'(rsp_sum[1]), 16'(11));
      checkOutput("cont_id2", 16'(rsp_id[2]), 16'(0));
      checkOutput("cont_gap01", 16'(hs_cyc[1] - hs_cyc[0]), 16'(3));
      checkOutput("cont_gap12", 16'(hs_cyc[2] - hs_cyc[1]), 16'(3));
    end
    finishOp();

    // Reset during CALC
    tick(); r0_valid = 1'b1; r0_a = 4'd7; r0_b = 4'd7;
    hs0 = 1'b0;
    for (int i = 0; i < 30 && !hs0; i++) begin
      @(negedge clk);
      if (r0_ready) hs0 = 1'b1;
      tick();
    end
    r0_valid = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_busy", 16'(busy), 16'(0));
    checkOutput("rst_mid_count", 16'(op_count), 16'(0));
    for (int k = 0; k < 4; k++) begin
      checkOutput("rst_mid_no_resp", 16'(resp_valid), 16'(0));
      @(negedge clk);
    end
    tick(); r0_valid = 1'b1; r0_a = 4'd1; r0_b = 4'd1; r1_valid = 1'b1; r1_a = 4'd2; r1_b = 4'd2;
    @(negedge clk);
    checkOutput("rst_mid_prio_r0", 16'(r0_ready), 16'(1));
    checkOutput("rst_mid_prio_r1", 16'(r1_ready), 16'(0));
    tick(); r0_valid = 1'b0; r1_valid = 1'b0;
    waitResp(s, id, lat);
    checkOutput("rst_mid_after_sum", 16'(s), 16'(2));
    finishOp();

    // Counter wrap
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k[0], 4'(k), 4'd3, 1'b0, s, id, lat);
      finishOp();
      checkOutput("op_count_wrap", 16'(op_count), 16'(wrap_exp[k]));
    end

    // Randomized traffic against the model
    doReset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      hs0 = r0_valid && r0_ready;
      hs1 = r1_valid && r1_ready;
      tick();
      if (hs0 || (!r0_valid && $urandom_range(0, 2) == 0)) begin
        r0_valid = ($urandom_range(0, 1) == 1); r0_a = 4'($urandom); r0_b = 4'($urandom);
      end else if (r0_valid && $urandom_range(0, 15) == 0) r0_valid = 1'b0;
      if (hs1 || (!r1_valid && $urandom_range(0, 2) == 0)) begin
        r1_valid = ($urandom_range(0, 1) == 1); r1_a = 4'($urandom); r1_b = 4'($urandom);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    r0_valid = 1'b0; r1_valid = 1'b0; resp_ready = 1'b1;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
